// File: rtl/rename_regfile_if.sv
// Decoder/ROB-side bus of the rename register file: commit, issue, operand
// lookup with ROB forwarding, and branch checkpoint control.
interface rename_regfile_if #(
    parameter int unsigned ROB_WIDTH = 4,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned NUM_CKPT  = 4
);
    localparam int unsigned CK_W = $clog2(NUM_CKPT);

    logic                          rdy_in;
    logic                          clear;
    logic [4:0]                    commit_reg_id;
    logic [31:0]                   commit_val;
    logic [ROB_WIDTH-1:0]          commit_rob_id;
    logic [4:0]                    issue_reg_id;
    logic [ROB_WIDTH-1:0]          issue_rob_id;
    logic [5*NUM_RD-1:0]           get_reg;
    logic [32*NUM_RD-1:0]          get_val;
    logic [NUM_RD-1:0]             has_dep;
    logic [ROB_WIDTH*NUM_RD-1:0]   get_dep;
    logic [ROB_WIDTH*NUM_RD-1:0]   search_rob_id;
    logic [NUM_RD-1:0]             search_ready;
    logic [32*NUM_RD-1:0]          search_val;
    logic                          ckpt_save;
    logic [CK_W-1:0]               ckpt_id;
    logic                          ckpt_full;
    logic                          ckpt_release;
    logic                          ckpt_restore;
    logic [CK_W-1:0]               ckpt_restore_id;

    // Decoder / ROB side
    modport master (
        output rdy_in, clear, commit_reg_id, commit_val, commit_rob_id,
        output issue_reg_id, issue_rob_id, get_reg, search_ready, search_val,
        output ckpt_save, ckpt_release, ckpt_restore, ckpt_restore_id,
        input  get_val, has_dep, get_dep, search_rob_id, ckpt_id, ckpt_full
    );

    // Register file side
    modport slave (
        input  rdy_in, clear, commit_reg_id, commit_val, commit_rob_id,
        input  issue_reg_id, issue_rob_id, get_reg, search_ready, search_val,
        input  ckpt_save, ckpt_release, ckpt_restore, ckpt_restore_id,
        output get_val, has_dep, get_dep, search_rob_id, ckpt_id, ckpt_full
    );
endinterface

// File: rtl/rename_regfile.sv
// Architectural register file with per-register rename tags, ROB-forwarded
// operand reads and a circular buffer of rename-table checkpoints.
module rename_regfile #(
    parameter int unsigned ROB_WIDTH = 4,
    parameter int unsigned NUM_RD    = 2,
    parameter int unsigned NUM_CKPT  = 4
) (
    input  logic           clk_in,
    input  logic           rst_in,
    rename_regfile_if.slave rf
);
    localparam int unsigned CK_W     = $clog2(NUM_CKPT);
    localparam int unsigned CNT_W    = CK_W + 1;
    localparam int unsigned NUM_REGS = 32;

    logic [31:0]          val_q    [NUM_REGS];
    logic [ROB_WIDTH-1:0] tag_q    [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_q;
    logic [ROB_WIDTH-1:0] s_tag_q  [NUM_CKPT][NUM_REGS];
    logic [NUM_REGS-1:0]  s_busy_q [NUM_CKPT];
    logic [CK_W-1:0]      head_q;
    logic [CK_W-1:0]      tail_q;
    logic [CNT_W-1:0]     count_q;

    logic                 commit_en;
    logic                 issue_en;
    logic                 live_hit;
    logic [NUM_CKPT-1:0]  snap_hit;
    logic [ROB_WIDTH-1:0] tag_cc   [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_cc;
    logic [ROB_WIDTH-1:0] tag_rs   [NUM_REGS];
    logic [NUM_REGS-1:0]  busy_rs;
    logic [CK_W-1:0]      head_rel;
    logic [CK_W-1:0]      restore_dist;
    logic [4:0]           rd_sel;

    // Commit tag matching, post-commit live table and restore candidate table
    always_comb begin
        commit_en = (rf.commit_reg_id != 5'd0);
        issue_en  = (rf.issue_reg_id != 5'd0);
        live_hit  = commit_en && busy_q[rf.commit_reg_id]
                    && (tag_q[rf.commit_reg_id] == rf.commit_rob_id);
        snap_hit  = '0;
        for (int unsigned j = 0; j < NUM_CKPT; j++) begin
            snap_hit[j] = commit_en && s_busy_q[j][rf.commit_reg_id]
                          && (s_tag_q[j][rf.commit_reg_id] == rf.commit_rob_id);
        end
        tag_cc  = tag_q;
        busy_cc = busy_q;
        if (live_hit) begin
            tag_cc[rf.commit_reg_id]  = '0;
            busy_cc[rf.commit_reg_id] = 1'b0;
        end
        tag_rs  = s_tag_q[rf.ckpt_restore_id];
        busy_rs = s_busy_q[rf.ckpt_restore_id];
        if (snap_hit[rf.ckpt_restore_id]) begin
            tag_rs[rf.commit_reg_id]  = '0;
            busy_rs[rf.commit_reg_id] = 1'b0;
        end
        // A release in the restore cycle moves head before the distance is taken
        head_rel     = head_q + CK_W'(rf.ckpt_release);
        restore_dist = rf.ckpt_restore_id - head_rel;
    end

    // Operand lookup with ROB forwarding, plus checkpoint status
    always_comb begin
        rf.get_val       = '0;
        rf.has_dep       = '0;
        rf.get_dep       = '0;
        rf.search_rob_id = '0;
        rd_sel           = '0;
        for (int unsigned k = 0; k < NUM_RD; k++) begin
            rd_sel = rf.get_reg[5*k +: 5];
            rf.get_dep[ROB_WIDTH*k +: ROB_WIDTH]       = tag_q[rd_sel];
            rf.search_rob_id[ROB_WIDTH*k +: ROB_WIDTH] = tag_q[rd_sel];
            rf.has_dep[k] = busy_q[rd_sel] & ~rf.search_ready[k];
            rf.get_val[32*k +: 32] = busy_q[rd_sel] ? rf.search_val[32*k +: 32]
                                                    : val_q[rd_sel];
        end
        rf.ckpt_full = (count_q == CNT_W'(NUM_CKPT));
        rf.ckpt_id   = tail_q;
    end

    // Table, snapshot and pointer update
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                val_q[i] <= '0;
                tag_q[i] <= '0;
            end
            busy_q <= '0;
            for (int unsigned j = 0; j < NUM_CKPT; j++) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    s_tag_q[j][i] <= '0;
                end
                s_busy_q[j] <= '0;
            end
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (rf.rdy_in) begin
            if (commit_en) begin
                val_q[rf.commit_reg_id] <= rf.commit_val;
            end
            if (rf.clear) begin
                for (int unsigned i = 0; i < NUM_REGS; i++) begin
                    tag_q[i] <= '0;
                end
                busy_q  <= '0;
                head_q  <= '0;
                tail_q  <= '0;
                count_q <= '0;
            end else if (rf.ckpt_restore) begin
                tag_q   <= tag_rs;
                busy_q  <= busy_rs;
                head_q  <= head_rel;
                tail_q  <= rf.ckpt_restore_id;
                count_q <= {1'b0, restore_dist};
                for (int unsigned j = 0; j < NUM_CKPT; j++) begin
                    if (snap_hit[j]) begin
                        s_tag_q[j][rf.commit_reg_id]  <= '0;
                        s_busy_q[j][rf.commit_reg_id] <= 1'b0;
                    end
                end
            end else begin
                tag_q  <= tag_cc;
                busy_q <= busy_cc;
                // Issue lands after the commit clear so it wins on the same rd
                if (issue_en) begin
                    tag_q[rf.issue_reg_id]  <= rf.issue_rob_id;
                    busy_q[rf.issue_reg_id] <= 1'b1;
                end
                // Snapshot excludes this cycle's issue (the branch's own rd)
                for (int unsigned j = 0; j < NUM_CKPT; j++) begin
                    if (rf.ckpt_save && (CK_W'(j) == tail_q)) begin
                        s_tag_q[j]  <= tag_cc;
                        s_busy_q[j] <= busy_cc;
                    end else if (snap_hit[j]) begin
                        s_tag_q[j][rf.commit_reg_id]  <= '0;
                        s_busy_q[j][rf.commit_reg_id] <= 1'b0;
                    end
                end
                tail_q  <= tail_q + CK_W'(rf.ckpt_save);
                head_q  <= head_rel;
                count_q <= count_q + CNT_W'(rf.ckpt_save) - CNT_W'(rf.ckpt_release);
            end
        end
    end
endmodule

// File: tb/tb_rename_regfile.sv
// Self-checking bench for rename_regfile: directed scenarios plus a random
// run against a queue-based model of the rename table and checkpoints.
module tb_rename_regfile;
    localparam int RW   = 4;
    localparam int NRD  = 2;
    localparam int NC   = 4;
    localparam int CK_W = 2;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk_in = ~clk_in;

    rename_regfile_if #(.ROB_WIDTH(RW), .NUM_RD(NRD), .NUM_CKPT(NC)) rf ();

    rename_regfile #(.ROB_WIDTH(RW), .NUM_RD(NRD), .NUM_CKPT(NC)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .rf     (rf)
    );

    // Reference model: live table in arrays, checkpoints as a FIFO of snapshots
    logic [31:0]      m_val  [32];
    logic [RW-1:0]    m_tag  [32];
    logic             m_busy [32];
    logic [32*RW-1:0] q_tag  [$];
    logic [31:0]      q_busy [$];
    int               m_head;

    function automatic void model_reset();
        for (int r = 0; r < 32; r++) begin
            m_val[r] = '0; m_tag[r] = '0; m_busy[r] = 1'b0;
        end
        q_tag.delete(); q_busy.delete();
        m_head = 0;
    endfunction

    function automatic void model_edge();
        int c; int idx;
        logic [32*RW-1:0] st; logic [31:0] sb;
        if (rst_in) begin model_reset(); return; end
        if (!rf.rdy_in) return;
        c = int'(rf.commit_reg_id);
        if (c != 0) m_val[c] = rf.commit_val;
        if (rf.clear) begin
            for (int r = 0; r < 32; r++) begin m_tag[r] = '0; m_busy[r] = 1'b0; end
            q_tag.delete(); q_busy.delete(); m_head = 0;
            return;
        end
        if (c != 0) begin
            if (m_busy[c] && m_tag[c] == rf.commit_rob_id) begin
                m_busy[c] = 1'b0; m_tag[c] = '0;
            end
            for (int i = 0; i < q_tag.size(); i++) begin
                st = q_tag[i]; sb = q_busy[i];
                if (sb[c] && st[c*RW +: RW] == rf.commit_rob_id) begin
                    sb[c] = 1'b0; st[c*RW +: RW] = '0;
                    q_tag[i] = st; q_busy[i] = sb;
                end
            end
        end
        if (rf.ckpt_restore) begin
            if (rf.ckpt_release) begin
                void'(q_tag.pop_front()); void'(q_busy.pop_front());
                m_head = (m_head + 1) % NC;
            end
            idx = (int'(rf.ckpt_restore_id) - m_head + NC) % NC;
            if (idx >= q_tag.size()) begin
                n_checks++; n_fail++;
                $display("FAIL illegal_restore: slot %0d not live (live count %0d)",
                         rf.ckpt_restore_id, q_tag.size());
                return;
            end
            st = q_tag[idx]; sb = q_busy[idx];
            for (int r = 0; r < 32; r++) begin
                m_tag[r] = st[r*RW +: RW]; m_busy[r] = sb[r];
            end
            while (q_tag.size() > idx) begin
                void'(q_tag.pop_back()); void'(q_busy.pop_back());
            end
            return;
        end
        if (rf.ckpt_save) begin
            for (int r = 0; r < 32; r++) begin
                st[r*RW +: RW] = m_tag[r]; sb[r] = m_busy[r];
            end
            q_tag.push_back(st); q_busy.push_back(sb);
        end
        if (rf.ckpt_release) begin
            void'(q_tag.pop_front()); void'(q_busy.pop_front());
            m_head = (m_head + 1) % NC;
        end
        if (rf.issue_reg_id != 5'd0) begin
            m_tag[rf.issue_reg_id]  = rf.issue_rob_id;
            m_busy[rf.issue_reg_id] = 1'b1;
        end
    endfunction

    function automatic logic [32*NRD-1:0] exp_get_val();
        logic [32*NRD-1:0] v; int r;
        v = '0;
        for (int k = 0; k < NRD; k++) begin
            r = int'(rf.get_reg[5*k +: 5]);
            v[32*k +: 32] = m_busy[r] ? rf.search_val[32*k +: 32] : m_val[r];
        end
        return v;
    endfunction

    function automatic logic [NRD-1:0] exp_has_dep();
        logic [NRD-1:0] v; int r;
        v = '0;
        for (int k = 0; k < NRD; k++) begin
            r = int'(rf.get_reg[5*k +: 5]);
            v[k] = m_busy[r] && !rf.search_ready[k];
        end
        return v;
    endfunction

    function automatic logic [RW*NRD-1:0] exp_get_dep();
        logic [RW*NRD-1:0] v; int r;
        v = '0;
        for (int k = 0; k < NRD; k++) begin
            r = int'(rf.get_reg[5*k +: 5]);
            v[RW*k +: RW] = m_tag[r];
        end
        return v;
    endfunction

    task automatic set_idle();
        rf.rdy_in = 1'b1; rf.clear = 1'b0;
        rf.commit_reg_id = '0; rf.commit_val = '0; rf.commit_rob_id = '0;
        rf.issue_reg_id = '0; rf.issue_rob_id = '0;
        rf.ckpt_save = 1'b0; rf.ckpt_release = 1'b0;
        rf.ckpt_restore = 1'b0; rf.ckpt_restore_id = '0;
        rf.search_ready = '0;
    endtask

    task automatic step();
        @(posedge clk_in);
        model_edge();
        #1;
        set_idle();
    endtask

    task automatic do_reset();
        set_idle(); rst_in = 1'b1; step(); rst_in = 1'b0;
    endtask

    task automatic read2(input logic [4:0] r0, input logic [4:0] r1, input logic [1:0] sr,
                         input logic [31:0] v0, input logic [31:0] v1);
        rf.get_reg = {r1, r0}; rf.search_ready = sr; rf.search_val = {v1, v0};
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        read2(5'd5, 5'd0, 2'b00, 32'h1234, 32'h5678);
        n_checks++; if (rf.ckpt_full !== 1'b0) begin n_fail++; $display("FAIL reset_full: got %b want 0", rf.ckpt_full); end
        n_checks++; if (rf.ckpt_id !== 2'd0) begin n_fail++; $display("FAIL reset_id: got %0d want 0", rf.ckpt_id); end
        n_checks++; if (rf.has_dep !== 2'b00) begin n_fail++; $display("FAIL reset_has_dep: got %b want 00", rf.has_dep); end
        n_checks++; if (rf.get_val !== 64'h0) begin n_fail++; $display("FAIL reset_get_val: got %h want 0", rf.get_val); end
    endtask

    task automatic test_rename_commit();
        do_reset();
        rf.issue_reg_id = 5'd5; rf.issue_rob_id = 4'd3; step();
        read2(5'd5, 5'd0, 2'b00, 32'h0, 32'h0);
        n_checks++; if (rf.has_dep !== 2'b01) begin n_fail++; $display("FAIL rc_has_dep: got %b want 01", rf.has_dep); end
        n_checks++; if (rf.get_dep[3:0] !== 4'd3) begin n_fail++; $display("FAIL rc_get_dep: got %0d want 3", rf.get_dep[3:0]); end
        n_checks++; if (rf.search_rob_id[3:0] !== 4'd3) begin n_fail++; $display("FAIL rc_search_id: got %0d want 3", rf.search_rob_id[3:0]); end
        read2(5'd5, 5'd0, 2'b01, 32'h11, 32'h0);
        n_checks++; if (rf.has_dep !== 2'b00) begin n_fail++; $display("FAIL rc_fwd_dep: got %b want 00", rf.has_dep); end
        n_checks++; if (rf.get_val[31:0] !== 32'h11) begin n_fail++; $display("FAIL rc_fwd_val: got %h want 11", rf.get_val[31:0]); end
        rf.commit_reg_id = 5'd5; rf.commit_val = 32'h11; rf.commit_rob_id = 4'd3; step();
        read2(5'd5, 5'd0, 2'b00, 32'hdeadbeef, 32'h0);
        n_checks++; if (rf.has_dep !== 2'b00) begin n_fail++; $display("FAIL rc_commit_dep: got %b want 00", rf.has_dep); end
        n_checks++; if (rf.get_val[31:0] !== 32'h11) begin n_fail++; $display("FAIL rc_commit_val: got %h want 11", rf.get_val[31:0]); end
    endtask

    task automatic test_stale_commit();
        do_reset();
        rf.issue_reg_id = 5'd5; rf.issue_rob_id = 4'd3; step();
        rf.issue_reg_id = 5'd5; rf.issue_rob_id = 4'd7; step();
        rf.commit_reg_id = 5'd5; rf.commit_val = 32'hAA; rf.commit_rob_id = 4'd3; step();
        read2(5'd5, 5'd0, 2'b00, 32'h0, 32'h0);
        n_checks++; if (rf.has_dep !== 2'b01) begin n_fail++; $display("FAIL stale_dep: got %b want 01", rf.has_dep); end
        n_checks++; if (rf.get_dep[3:0] !== 4'd7) begin n_fail++; $display("FAIL stale_tag: got %0d want 7", rf.get_dep[3:0]); end
        rf.clear = 1'b1; step();
        read2(5'd5, 5'd0, 2'b00, 32'h0, 32'h0);
        n_checks++; if (rf.get_val[31:0] !== 32'hAA) begin n_fail++; $display("FAIL stale_val: got %h want aa", rf.get_val[31:0]); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        rf.issue_reg_id = 5'd6; rf.issue_rob_id = 4'd9;
        rf.commit_reg_id = 5'd6; rf.commit_val = 32'h66; rf.commit_rob_id = 4'd2; step();
        read2(5'd6, 5'd0, 2'b00, 32'h0, 32'h0);
        n_checks++; if (rf.has_dep !== 2'b01) begin n_fail++; $display("FAIL same_dep: got %b want 01", rf.has_dep); end
        n_checks++; if (rf.get_dep[3:0] !== 4'd9) begin n_fail++; $display("FAIL same_tag: got %0d want 9", rf.get_dep[3:0]); end
        rf.clear = 1'b1; step();
        read2(5'd6, 5'd0, 2'b00, 32'h0, 32'h0);
        n_checks++; if (rf.get_val[31:0] !== 32'h66) begin n_fail++; $display("FAIL same_val: got %h want 66", rf.get_val[31:0]); end
    endtask

    task automatic test_ckpt_restore();
        for (int variant = 0; variant < 2; variant++) begin
            do_reset();
            rf.issue_reg_id = 5'd1; rf.issue_rob_id = 4'd1; step();
            rf.ckpt_save = 1'b1; step();
            rf.issue_reg_id = 5'd2; rf.issue_rob_id = 4'd2; step();
            rf.ckpt_save = 1'b1; step();
            rf.issue_reg_id = 5'd1; rf.issue_rob_id = 4'd3; step();
            #1;
            n_checks++; if (rf.ckpt_id !== 2'd2) begin n_fail++; $display("FAIL cr_pre_id v%0d: got %0d want 2", variant, rf.ckpt_id); end
            rf.ckpt_restore = 1'b1; rf.ckpt_restore_id = 2'd0;
            if (variant == 1) begin
                rf.commit_reg_id = 5'd1; rf.commit_val = 32'h55; rf.commit_rob_id = 4'd1;
            end
            step();
            read2(5'd1, 5'd2, 2'b00, 32'hcafe0001, 32'hcafe0002);
            n_checks++;
            if (rf.has_dep !== ((variant == 1) ? 2'b00 : 2'b01)) begin
                n_fail++; $display("FAIL cr_has_dep v%0d: got %b want %b", variant, rf.has_dep, (variant == 1) ? 2'b00 : 2'b01);
            end
            n_checks++;
            if (rf.get_dep[3:0] !== ((variant == 1) ? 4'd0 : 4'd1)) begin
                n_fail++; $display("FAIL cr_get_dep v%0d: got %0d want %0d", variant, rf.get_dep[3:0], (variant == 1) ? 0 : 1);
            end
            n_checks++;
            if (rf.get_val[31:0] !== ((variant == 1) ? 32'h55 : 32'hcafe0001)) begin
                n_fail++; $display("FAIL cr_get_val v%0d: got %h", variant, rf.get_val[31:0]);
            end
            n_checks++; if (rf.ckpt_id !== 2'd0) begin n_fail++; $display("FAIL cr_id v%0d: got %0d want 0", variant, rf.ckpt_id); end
            // Count back to zero: exactly four saves refill the buffer
            repeat (3) begin rf.ckpt_save = 1'b1; step(); end
            #1;
            n_checks++; if (rf.ckpt_full !== 1'b0) begin n_fail++; $display("FAIL cr_count3 v%0d: got %b want 0", variant, rf.ckpt_full); end
            rf.ckpt_save = 1'b1; step(); #1;
            n_checks++; if (rf.ckpt_full !== 1'b1) begin n_fail++; $display("FAIL cr_count4 v%0d: got %b want 1", variant, rf.ckpt_full); end
        end
    endtask

    task automatic test_full_wrap();
        do_reset();
        repeat (4) begin rf.ckpt_save = 1'b1; step(); end
        #1;
        n_checks++; if (rf.ckpt_full !== 1'b1) begin n_fail++; $display("FAIL fw_full: got %b want 1", rf.ckpt_full); end
        n_checks++; if (rf.ckpt_id !== 2'd0) begin n_fail++; $display("FAIL fw_id: got %0d want 0", rf.ckpt_id); end
        rf.ckpt_save = 1'b1; rf.ckpt_release = 1'b1; step(); #1;
        n_checks++; if (rf.ckpt_full !== 1'b1) begin n_fail++; $display("FAIL fw_sr_full: got %b want 1", rf.ckpt_full); end
        n_checks++; if (rf.ckpt_id !== 2'd1) begin n_fail++; $display("FAIL fw_sr_id: got %0d want 1", rf.ckpt_id); end
        rf.ckpt_restore = 1'b1; rf.ckpt_restore_id = 2'd2; step(); #1;
        n_checks++; if (rf.ckpt_full !== 1'b0) begin n_fail++; $display("FAIL fw_rs_full: got %b want 0", rf.ckpt_full); end
        n_checks++; if (rf.ckpt_id !== 2'd2) begin n_fail++; $display("FAIL fw_rs_id: got %0d want 2", rf.ckpt_id); end
        repeat (2) begin rf.ckpt_save = 1'b1; step(); end
        #1;
        n_checks++; if (rf.ckpt_full !== 1'b0) begin n_fail++; $display("FAIL fw_cnt3: got %b want 0", rf.ckpt_full); end
        rf.ckpt_save = 1'b1; step(); #1;
        n_checks++; if (rf.ckpt_full !== 1'b1) begin n_fail++; $display("FAIL fw_cnt4: got %b want 1", rf.ckpt_full); end
        n_checks++; if (rf.ckpt_id !== 2'd1) begin n_fail++; $display("FAIL fw_cnt4_id: got %0d want 1", rf.ckpt_id); end
    endtask

    task automatic test_hold_clear_reset();
        do_reset();
        rf.commit_reg_id = 5'd8; rf.commit_val = 32'h88; step();
        rf.issue_reg_id = 5'd7; rf.issue_rob_id = 4'd5; step();
        rf.ckpt_save = 1'b1; step();
        rf.rdy_in = 1'b0; rf.issue_reg_id = 5'd7; rf.issue_rob_id = 4'd6; rf.ckpt_save = 1'b1;
        rf.commit_reg_id = 5'd8; rf.commit_val = 32'h99; step();
        rf.rdy_in = 1'b0; rf.commit_reg_id = 5'd7; rf.commit_val = 32'h77; rf.commit_rob_id = 4'd5; step();
        read2(5'd7, 5'd8, 2'b00, 32'h0, 32'h0);
        n_checks++; if (rf.has_dep !== 2'b01) begin n_fail++; $display("FAIL hold_dep: got %b want 01", rf.has_dep); end
        n_checks++; if (rf.get_dep[3:0] !== 4'd5) begin n_fail++; $display("FAIL hold_tag: got %0d want 5", rf.get_dep[3:0]); end
        n_checks++; if (rf.get_val[63:32] !== 32'h88) begin n_fail++; $display("FAIL hold_val: got %h want 88", rf.get_val[63:32]); end
        n_checks++; if (rf.ckpt_id !== 2'd1) begin n_fail++; $display("FAIL hold_id: got %0d want 1", rf.ckpt_id); end
        rf.clear = 1'b1; step();
        read2(5'd7, 5'd8, 2'b00, 32'h0, 32'h0);
        n_checks++; if (rf.has_dep !== 2'b00) begin n_fail++; $display("FAIL clr_dep: got %b want 00", rf.has_dep); end
        n_checks++; if (rf.get_val !== {32'h88, 32'h0}) begin n_fail++; $display("FAIL clr_val: got %h", rf.get_val); end
        n_checks++; if (rf.ckpt_id !== 2'd0) begin n_fail++; $display("FAIL clr_id: got %0d want 0", rf.ckpt_id); end
        rf.issue_reg_id = 5'd9; rf.issue_rob_id = 4'd4; rf.ckpt_save = 1'b1; step();
        rst_in = 1'b1; step(); rst_in = 1'b0;
        read2(5'd9, 5'd8, 2'b00, 32'h1, 32'h2);
        n_checks++; if (rf.has_dep !== 2'b00) begin n_fail++; $display("FAIL rst_dep: got %b want 00", rf.has_dep); end
        n_checks++; if (rf.get_val !== 64'h0) begin n_fail++; $display("FAIL rst_val: got %h want 0", rf.get_val); end
        n_checks++; if (rf.ckpt_id !== 2'd0 || rf.ckpt_full !== 1'b0) begin n_fail++; $display("FAIL rst_ckpt: id %0d full %b want 0 0", rf.ckpt_id, rf.ckpt_full); end
    endtask

    task automatic test_random();
        int sz; int live; int r; logic rel;
        do_reset();
        for (int cyc = 0; cyc < 800; cyc++) begin
            rst_in    = ($urandom_range(0, 199) == 0);
            rf.rdy_in = ($urandom_range(0, 9) != 0);
            rf.clear  = ($urandom_range(0, 59) == 0);
            r = $urandom_range(0, 7);
            rf.commit_reg_id = 5'(r);
            rf.commit_val    = $urandom;
            rf.commit_rob_id = (m_busy[r] && $urandom_range(0, 2) != 0) ? m_tag[r] : 4'($urandom);
            rf.issue_reg_id  = 5'($urandom_range(0, 7));
            rf.issue_rob_id  = 4'($urandom);
            sz   = q_tag.size();
            rel  = (sz > 0) && ($urandom_range(0, 3) == 0);
            live = sz - int'(rel);
            rf.ckpt_release = rel;
            rf.ckpt_restore = (live > 0) && ($urandom_range(0, 7) == 0);
            rf.ckpt_restore_id = rf.ckpt_restore
                ? CK_W'((m_head + int'(rel) + int'($urandom_range(0, live - 1))) % NC) : '0;
            rf.ckpt_save = (sz < NC || rel) && ($urandom_range(0, 2) == 0);
            rf.get_reg      = {5'($urandom_range(0, 9)), 5'($urandom_range(0, 9))};
            rf.search_ready = 2'($urandom);
            rf.search_val   = {$urandom, $urandom};
            #1;
            n_checks++; if (rf.get_val !== exp_get_val()) begin n_fail++; $display("FAIL rnd_get_val c%0d: got %h want %h", cyc, rf.get_val, exp_get_val()); end
            n_checks++; if (rf.has_dep !== exp_has_dep()) begin n_fail++; $display("FAIL rnd_has_dep c%0d: got %b want %b", cyc, rf.has_dep, exp_has_dep()); end
            n_checks++; if (rf.get_dep !== exp_get_dep()) begin n_fail++; $display("FAIL rnd_get_dep c%0d: got %h want %h", cyc, rf.get_dep, exp_get_dep()); end
            n_checks++; if (rf.search_rob_id !== exp_get_dep()) begin n_fail++; $display("FAIL rnd_search_id c%0d: got %h want %h", cyc, rf.search_rob_id, exp_get_dep()); end
            n_checks++; if (rf.ckpt_id !== CK_W'((m_head + q_tag.size()) % NC)) begin n_fail++; $display("FAIL rnd_ckpt_id c%0d: got %0d want %0d", cyc, rf.ckpt_id, (m_head + q_tag.size()) % NC); end
            n_checks++; if (rf.ckpt_full !== (q_tag.size() == NC)) begin n_fail++; $display("FAIL rnd_ckpt_full c%0d: got %b want %b", cyc, rf.ckpt_full, q_tag.size() == NC); end
            step();
        end
        rst_in = 1'b0;
    endtask

    initial begin
        model_reset();
        set_idle();
        rf.get_reg = '0; rf.search_val = '0;
        test_reset();
        test_rename_commit();
        test_stale_commit();
        test_same_cycle();
        test_ckpt_restore();
        test_full_wrap();
        test_hold_clear_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/rename_regfile.md
# rename_regfile

Parametrised architectural register file with rename tags and branch checkpoints, sitting between the decoder/issue stage and the ROB. It holds committed register values and, per register, the ROB entry that will produce its next value. It serves `NUM_RD` combinational operand lookups with ROB forwarding. Unlike the flat clear-only design, it takes up to `NUM_CKPT` snapshots of the rename table at branch issue and restores a single snapshot on a mispredict, so younger branches' speculation is discarded without flushing older in-flight work.

## Interface
- `ROB_WIDTH`, 4: ROB index width.
- `NUM_RD`, 2: operand read ports (1..4).
- `NUM_CKPT`, 4: checkpoint slots (power of two, ≥2); `CK_W = log2(NUM_CKPT)`.

Ports:
- `clk_in` in 1: clock, all state updates on rising edge.
- `rst_in` in 1: synchronous, active-high reset.
- `rdy_in` in 1: when low, all state holds and inputs are ignored.
- `clear` in 1: full flush. Drops all tags and all checkpoints.
- `commit_reg_id` in 5: committing rd; 0 = no commit.
- `commit_val` in 32: committed value.
- `commit_rob_id` in ROB_WIDTH: ROB entry committing.
- `issue_reg_id` in 5: renamed rd; 0 = no rename.
- `issue_rob_id` in ROB_WIDTH: tag assigned to `issue_reg_id`.
- `get_reg` in 5*NUM_RD: packed read register ids, port k at bits [5k+4:5k].
- `get_val` out 32*NUM_RD: operand values.
- `has_dep` out NUM_RD: operand still pending.
- `get_dep` out ROB_WIDTH*NUM_RD: producer tag.
- `search_rob_id` out ROB_WIDTH*NUM_RD: ROB lookup tag per port.
- `search_ready` in NUM_RD: ROB entry has its result.
- `search_val` in 32*NUM_RD: ROB entry result.
- `ckpt_save` in 1: take a snapshot (branch issue).
- `ckpt_id` out CK_W: slot that the next save will use (the tail).
- `ckpt_full` out 1: no free slot; saving while full is illegal.
- `ckpt_release` in 1: oldest checkpoint is no longer needed (branch committed); head advances.
- `ckpt_restore` in 1: mispredict recovery.
- `ckpt_restore_id` in CK_W: slot to restore.

## Operation
- **State:**
  - `val[32]`, `tag[32]`, `busy[32]`.
  - Snapshot arrays `s_tag[NUM_CKPT][32]`, `s_busy[NUM_CKPT][32]`.
  - Pointers `head` and `tail` (CK_W bits, wrapping).
  - `count` (CK_W+1 bits).
- **Register 0:** x0 is never written and never busy. `get_val` is 0 for x0.
- **Read port k (combinational):**
  - `search_rob_id[k] = get_dep[k] = tag[r]`.
  - `has_dep[k] = busy[r] & ~search_ready[k]`.
  - `get_val[k] = busy[r] ? search_val[k] : val[r]`.
  - No bypass of the same-cycle commit into `val`; the ROB search path covers it.
- **Commit** (`commit_reg_id != 0`):
  - Write `val[rd] <= commit_val`.
  - If `busy[rd] && tag[rd] == commit_rob_id`, clear `busy[rd]` and set `tag[rd] <= 0`.
  - The same match-and-clear is applied to every live snapshot slot, so restored tables never point at retired entries.
- **Issue** (`issue_reg_id != 0`): `tag[rd] <= issue_rob_id`, `busy[rd] <= 1`. On the same register, issue overrides the commit clear. The commit value is still written.
- **Save:**
  - `s_*[tail]` receives the live table after this cycle's commit clear and before this cycle's issue. The branch's own rd rename is therefore not in its snapshot.
  - Then `tail++`, `count++`.
- **Release:** `head++`, `count--`.
- **Restore:**
  - `tag/busy <= s_*[ckpt_restore_id]`, with this cycle's commit clear applied on top.
  - Same-cycle issue and save are ignored.
  - `tail <= ckpt_restore_id`; `count <= (ckpt_restore_id - head) mod NUM_CKPT`. The restored slot and all younger slots are freed.
  - A same-cycle release is applied first: `head++`, and count is computed with the new head.
- **Priority:** `rst_in` > `!rdy_in` > `clear` > `ckpt_restore` > normal.
  - Normal covers commit, issue, save and release together.
  - `clear` zeros `tag/busy` and sets `head = tail = count = 0`. `val` is kept. The commit value is written in a `clear` cycle; its tag clear is subsumed.
- **Status outputs:** `ckpt_full = (count == NUM_CKPT)`; `ckpt_id = tail`.
- **Illegal inputs** (bench asserts, RTL need not handle): save while full without a same-cycle release; release while `count == 0`; restore of a slot not live.

## Timing
- Reads are zero-latency combinational. Table updates are visible on the next cycle.
- A register renamed in cycle t reads `has_dep=1` with `get_dep=issue_rob_id` in cycle t+1.
- A restore in cycle t is visible at read ports in t+1. `ckpt_full` drops in t+1.
- Save and release in the same cycle leave `count` unchanged; this is legal when full.
- Wrap-around: the pointers are modulo NUM_CKPT. `count` distinguishes full from empty.
- Reset values: all `val = 0`, `tag = 0`, `busy = 0`, `head = tail = count = 0`. Hence `ckpt_full = 0`, `ckpt_id = 0`, `has_dep = 0`, `get_val = 0` for every port.
- Reset while checkpoints are live discards them with no residual state.

## Test plan
- **Rename/commit:** issue x5→tag 3; next cycle read x5 gives `has_dep=1`, `get_dep=3`. Set `search_ready=1` with val 0x11 → `has_dep=0`, `get_val=0x11`. Commit x5/tag 3/0x11 → `busy` clears; read returns 0x11 with no ROB hit.
- **Stale commit:** issue x5→3, then x5→7, then commit x5/tag 3 with 0xAA → `val[x5]=0xAA`, x5 still busy with tag 7.
- **Same-cycle issue and commit on x6:** issue→9, commit tag 2 → x6 busy, tag 9, `val` updated.
- **Checkpoint restore:**
  - Setup: issue x1→1; save (slot 0); issue x2→2; save (slot 1); issue x1→3.
  - Restore 0 → x1 tag 1 busy, x2 not busy, `ckpt_id=0`, `count=0`.
  - Repeat the setup with commit x1/tag 1 during the restore cycle → x1 not busy after restore.
- **Full/wrap:** NUM_CKPT=4. Four saves → `ckpt_full=1`, `ckpt_id=0`. Release and save in the same cycle → still full, `ckpt_id=1`. Restore slot 2 with head=1 → `count=1`.
- **Hold/clear/reset:** with `rdy_in=0`, issue/save/commit have no effect. `clear` → all `has_dep=0`, `ckpt_full=0`, values kept. `rst_in` mid-stream → all outputs at reset values next cycle.
